apb_requester: RTL and testbench
================================

// Module: apb_requester
// PURPOSE
// - APB3 requester (initiator) that turns a valid/ready command stream into APB transfers.
// - Drives PSEL/PENABLE/PADDR/PWRITE/PWDATA and samples PRDATA/PREADY/PSLVERR.
// - Returns one response per command on a valid/ready response channel.
// - Sits in the equivalence bench as the shared stimulus source for both completer DUTs.
// PARAMETERS
// - ADDR_W   default 8   PADDR / cmd_addr width.
// - DATA_W   default 32  PWDATA / PRDATA / data-path width.
// - TIMEOUT  default 16  max ACCESS cycles waiting for PREADY; 0 disables the timeout.
// PORTS
// - PCLK        in   1       clock; all logic on posedge.
// - PRESETn     in   1       asynchronous, active-low reset.
// - cmd_valid   in   1       command present.
// - cmd_ready   out  1       command accepted when cmd_valid && cmd_ready.
// - cmd_write   in   1       1 = write, 0 = read.
// - cmd_addr    in   ADDR_W  transfer address.
// - cmd_wdata   in   DATA_W  write data; ignored for reads.
// - rsp_valid   out  1       response present.
// - rsp_ready   in   1       response consumed when rsp_valid && rsp_ready.
// - rsp_rdata   out  DATA_W  read data; 0 for writes and on timeout.
// - rsp_err     out  1       PSLVERR was sampled, or the transfer timed out.
// - rsp_timeout out  1       the transfer was aborted by the timeout.
// - PSEL, PENABLE, PWRITE  out  1 each  APB control.
// - PADDR       out  ADDR_W  APB address.
// - PWDATA      out  DATA_W  APB write data.
// - PRDATA      in   DATA_W  APB read data.
// - PREADY      in   1       APB ready.
// - PSLVERR     in   1       APB error.
// BEHAVIOUR
// - Reset: all outputs 0, FSM in IDLE, timeout count 0.
// - FSM states:
//   - IDLE: cmd_ready=1. On accept, latch write/addr/wdata -> SETUP.
//   - SETUP: PSEL=1, PENABLE=0 for exactly one cycle -> ACCESS.
//   - ACCESS: PSEL=1, PENABLE=1.
//     - PREADY=1: sample PRDATA (reads only) and PSLVERR -> RESP.
//     - Otherwise increment the wait count.
//     - TIMEOUT!=0 and count reaches TIMEOUT with PREADY still 0: abort -> RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//   - RESP: PSEL=PENABLE=0, rsp_valid=1, payload held stable until rsp_ready -> IDLE.
// - cmd_ready is 1 only in IDLE; a command is never accepted while another is in flight.
// - PADDR/PWRITE/PWDATA are registered; they stay stable from SETUP through the last ACCESS cycle.
// - They hold their last value in IDLE/RESP; PWDATA is 0 for reads.
// - Latency with zero-wait completer:
//   - accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3.
//   - Minimum command-to-command spacing is 4 cycles.
// - Wait count is 0 on entry to ACCESS and is not cleared by PREADY=0 cycles; width is $clog2(TIMEOUT+1).
// - PREADY=1 in the same cycle the count reaches TIMEOUT: completes normally, no timeout.
// - PREADY, PRDATA and PSLVERR are ignored outside ACCESS.
// - rsp_ready held high in IDLE has no effect; a held rsp_valid never drops without a handshake.
// - Reset mid-transfer: PSEL/PENABLE/rsp_valid drop immediately (async); the command is lost, no response.
// STRUCTURE
// - apb_pkg: typedef enum apb_req_state_e {IDLE,SETUP,ACCESS,RESP}.
// - apb_pkg: typedef struct apb_cmd_t {write, addr, wdata}, parameterised via localparams.
// - apb_pkg: typedef struct apb_rsp_t {rdata, err, timeout}.
// - One sub-module: apb_timeout_counter (PCLK, PRESETn, clear, enable, expired).
// - TIMEOUT=0 ties expired to 0.
// TESTING
// - Write 0x10<=0xDEADBEEF, PREADY=1 at first ACCESS -> PSEL cycles 1-2, PENABLE cycle 2, rsp_valid cycle 3, rsp_err=0.
// - Read 0x10, completer returns 0xDEADBEEF after 3 wait states -> PENABLE 4 cycles, rsp_rdata=0xDEADBEEF.
// - Read with PSLVERR=1 at completion -> rsp_err=1, rsp_timeout=0; next command still accepted afterwards.
// - PREADY held 0, TIMEOUT=16 -> abort after 16 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
// - rsp_ready held 0 for 5 cycles, cmd_valid held 1 -> cmd_ready=0 and response payload stable throughout.
// - PRESETn pulsed low during ACCESS -> PSEL/PENABLE/rsp_valid 0 at once; after release, IDLE with cmd_ready=1.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types for the APB requester: FSM state encoding and command/response records.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 8;
    localparam int unsigned APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_req_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS wait cycles; expired fires on the cycle whose PREADY=0 would bring the count
// to TIMEOUT. TIMEOUT=0 disables expiry.
module apb_timeout_counter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (TIMEOUT != 0) && enable && (count_q == CntW'(TIMEOUT - 1));

endmodule

// File: rtl/apb_requester.sv
// APB3 requester: accepts one command at a time, runs SETUP/ACCESS, returns one response.
module apb_requester
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_req_state_e    state_q, state_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              cnt_clear, cnt_en, expired;

    always_comb begin
        state_d   = state_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        tmo_d     = tmo_q;
        cnt_clear = 1'b1;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_write ? cmd_wdata : '0;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                cnt_clear = 1'b0;
                cnt_en    = !PREADY;
                if (PREADY) begin
                    state_d = RESP;
                    rdata_d = pwrite_q ? '0 : PRDATA;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                end else if (expired) begin
                    state_d = RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q  <= IDLE;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    apb_timeout_counter #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .expired(expired)
    );

    // Gated by reset so every output reads 0 while PRESETn is asserted.
    assign cmd_ready   = (state_q == IDLE) && PRESETn;
    assign PSEL        = (state_q == SETUP) || (state_q == ACCESS);
    assign PENABLE     = (state_q == ACCESS);
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester with a response scoreboard and per-transfer APB checks.
module tb_apb_requester;
    import apb_pkg::*;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [7:0]  PADDR;
    logic [31:0] PWDATA, PRDATA;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    apb_rsp_t sb_q[$];

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    apb_requester #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(16)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_write  (cmd_write),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PWRITE     (PWRITE),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // waits < 0 means PREADY never rises; hold = cycles rsp_ready is kept low with cmd_valid=1.
    task automatic do_xfer(input logic w, input logic [7:0] a, input logic [31:0] wd,
                           input int waits, input logic [31:0] rd, input logic e,
                           input int hold);
        apb_rsp_t exp;
        apb_rsp_t got;
        int       exp_acc;
        int       acc;
        int       t0;
        logic     to;
        to        = (waits < 0) || (waits >= 16);
        exp.timeout = to;
        exp.err   = to ? 1'b1 : e;
        exp.rdata = (to || w) ? 32'h0 : rd;
        exp_acc   = to ? 16 : waits + 1;
        sb_q.push_back(exp);

        @(posedge PCLK); #1;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        @(negedge PCLK);
        chk("cmd_ready_idle", cmd_ready, 1'b1);
        t0 = cyc;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_wdata = 32'hFFFF_FFFF;
        PREADY    = 1'b1;  // ignored during SETUP
        PSLVERR   = 1'b1;
        @(negedge PCLK);
        chk("setup_sel_en", {PSEL, PENABLE, cmd_ready}, 3'b100);
        chk("setup_paddr", PADDR, a);
        chk("setup_pwrite", PWRITE, w);
        chk("setup_pwdata", PWDATA, w ? wd : 32'h0);
        @(posedge PCLK); #1;

        acc = 0;
        for (int i = 0; i < 40; i++) begin
            PREADY  = (waits >= 0) && (i == waits);
            PSLVERR = PREADY ? e : 1'b0;
            PRDATA  = rd;
            @(negedge PCLK);
            if (!PENABLE) break;
            acc++;
            @(posedge PCLK); #1;
        end
        chk("access_cycles", acc, exp_acc);
        chk("resp_valid", {rsp_valid, PSEL, PENABLE}, 3'b100);
        chk("resp_latency", cyc - t0, 2 + exp_acc);
        chk("resp_paddr_held", PADDR, a);

        if (hold > 0) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b1;
            cmd_addr  = 8'h99;
            for (int k = 0; k < hold; k++) begin
                chk("hold_cmd_ready", cmd_ready, 1'b0);
                chk("hold_rsp_valid", rsp_valid, 1'b1);
                chk("hold_payload", {rsp_rdata, rsp_err, rsp_timeout}, exp);
                @(posedge PCLK); #1;
                @(negedge PCLK);
            end
            cmd_valid = 1'b0;
        end

        rsp_ready = 1'b1;
        chk("sb_nonempty", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
            got = sb_q.pop_front();
            chk("rsp_payload", {rsp_rdata, rsp_err, rsp_timeout}, got);
        end
        @(posedge PCLK); #1;
        rsp_ready = 1'b0;
        @(negedge PCLK);
        chk("post_rsp_idle", {rsp_valid, cmd_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 8'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b0;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        #2;
        chk("reset_ctrl", {cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_err, rsp_timeout},
            7'b0);
        chk("reset_data", {PADDR, PWDATA, rsp_rdata}, 72'h0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("release_ready", cmd_ready, 1'b1);

        do_xfer(1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h5555_5555, 1'b0, 0);
        do_xfer(1'b0, 8'h10, 32'h0, 3, 32'hDEAD_BEEF, 1'b0, 0);
        do_xfer(1'b0, 8'h24, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 0);
        do_xfer(1'b1, 8'h30, 32'h0102_0304, 0, 32'h0, 1'b0, 0);
        do_xfer(1'b0, 8'h44, 32'h0, -1, 32'h1234_5678, 1'b0, 0);
        do_xfer(1'b0, 8'h48, 32'h0, 15, 32'hA5A5_A5A5, 1'b0, 0);
        do_xfer(1'b1, 8'h50, 32'h0BAD_F00D, 0, 32'h0, 1'b0, 5);

        // Reset during ACCESS: the in-flight command is dropped without a response.
        @(posedge PCLK); #1;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 8'h60;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        PREADY = 1'b0;
        @(posedge PCLK); #1;
        @(negedge PCLK);
        chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
        #2 PRESETn = 1'b0;
        #1;
        chk("async_reset_drop", {PSEL, PENABLE, rsp_valid, cmd_ready}, 4'b0);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        @(negedge PCLK);
        chk("after_reset_idle", {cmd_ready, PSEL, PENABLE, rsp_valid}, 4'b1000);

        do_xfer(1'b0, 8'h10, 32'h0, 0, 32'h1122_3344, 1'b0, 0);
        chk("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
